// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Owns the PC and the instruction-memory handshake. Each fetched
//             RV32I word is held for the decode stage until it is accepted.
//             Branch/jump redirects are honoured, including ones that arrive
//             while a memory request is still outstanding.
//  Options  : IFU_PERF_CNT_EN - build the fetch/stall performance counters;
//             when undefined both counter outputs are constant zero.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   // FETCH: request outstanding, HOLD: word presented, DRAIN: waiting out a
   // request made obsolete by a redirect.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] pend_reg, pend_next;
   logic [31:0] instr_reg, instr_next;
   logic        valid_reg, valid_next;
   logic [31:0] target_aligned;
   logic        unused_target_bits;

   // Low target bits are architecturally ignored; fetches are word aligned.
   assign target_aligned     = {redirect_target[31:2], 2'b00};
   assign unused_target_bits = ^redirect_target[1:0];

   // A request stays asserted in DRAIN so an issued fetch is never withdrawn.
   assign imem_req    = (state != HOLD);
   assign imem_addr   = pc_reg;
   assign pc          = pc_reg;
   assign instr_valid = valid_reg;
   assign instruction = instr_reg;

   // State and datapath registers; reset abandons any outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc_reg    <= RESET_PC;
         pend_reg  <= RESET_PC;
         instr_reg <= NOP_INSTR;
         valid_reg <= 1'b0;
      end else begin
         state     <= state_next;
         pc_reg    <= pc_next;
         pend_reg  <= pend_next;
         instr_reg <= instr_next;
         valid_reg <= valid_next;
      end
   end

   // Next-state and datapath decisions; redirect outranks everything but rst.
   always_comb begin
      state_next = state;
      pc_next    = pc_reg;
      pend_next  = pend_reg;
      instr_next = instr_reg;
      valid_next = valid_reg;
      case (state)
         FETCH: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  // Returned word belongs to the old path: drop it.
                  pc_next = target_aligned;
               end else begin
                  pend_next  = target_aligned;
                  state_next = DRAIN;
               end
            end else if (imem_ack) begin
               instr_next = imem_rdata;
               valid_next = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_next    = target_aligned;
               valid_next = 1'b0;
               instr_next = NOP_INSTR;
               state_next = FETCH;
            end else if (instr_ready) begin
               pc_next    = pc_reg + 32'd4;
               valid_next = 1'b0;
               instr_next = NOP_INSTR;
               state_next = FETCH;
            end
         end
         DRAIN: begin
            // Later redirects replace the pending target; the latest wins,
            // even when it coincides with the draining ack.
            if (redirect_valid) begin
               pend_next = target_aligned;
            end
            if (imem_ack) begin
               pc_next    = redirect_valid ? target_aligned : pend_reg;
               state_next = FETCH;
            end
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   // Count accepted instructions and memory wait cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if ((state == HOLD) && instr_ready && !redirect_valid) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (imem_req && !imem_ack) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign fetch_count = fetch_cnt;
   assign stall_count = stall_cnt;
`else
   assign fetch_count = 32'd0;
   assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire
